// File: rtl/note_link_if.sv
// Bundles the two note-vector source channels and the serial link outputs of the scheduler.
interface note_link_if #(
  parameter int NOTES = 48
);
  logic             game_valid;
  logic [NOTES-1:0] game_notes;
  logic             game_ready;
  logic             diag_valid;
  logic [NOTES-1:0] diag_notes;
  logic             diag_ready;
  logic             hold;
  logic             note_serial_sync;
  logic             note_serial_data;
  logic             frame_start;
  logic             owner;
  logic             refresh;

  modport master (
    output game_valid, game_notes, diag_valid, diag_notes, hold,
    input  game_ready, diag_ready, note_serial_sync, note_serial_data,
           frame_start, owner, refresh
  );

  modport slave (
    input  game_valid, game_notes, diag_valid, diag_notes, hold,
    output game_ready, diag_ready, note_serial_sync, note_serial_data,
           frame_start, owner, refresh
  );
endinterface

// File: rtl/note_link_scheduler.sv
// Serial note link owner: bit timing, DATA/PAD/SYNC framing and per-frame arbitration of two sources.
// Optional: NOTE_LINK_DIAG_PRIORITY_EN gives diag strict priority and lets it bypass hold.
module note_link_scheduler #(
  parameter int NOTES     = 48,
  parameter int BIT_DIV   = 8192,
  parameter int FRAME_LEN = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  note_link_if.slave  link
);
  localparam int DW   = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam int SW   = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int SRCS = 2;

  typedef enum logic [1:0] {PH_IDLE, PH_DATA, PH_PAD, PH_SYNC} phase_e;

  logic [DW-1:0]                  div_cnt_q;
  logic                           tick;
  phase_e                         ph_q, ph_d;
  logic [SW-1:0]                  slot_q, slot_d;
  logic                           boundary;
  logic [NOTES-1:0]               shadow_q, shadow_d;
  logic                           last_grant_q;
  logic                           owner_q, refresh_q;
  logic                           data_q, data_d, sync_q;
  logic                           frame_start_q;
  logic                           game_ready_q, diag_ready_q;
  logic [SRCS-1:0]                src_vld;
  logic [SRCS-1:0][NOTES-1:0]     src_notes;
  logic [SRCS-1:0]                gnt;
  logic                           bit_sel;

  // Source index 0 = game, 1 = diag; matches the owner encoding.
  assign src_vld   = {link.diag_valid, link.game_valid};
  assign src_notes = {link.diag_notes, link.game_notes};

  assign tick = (div_cnt_q == DW'(BIT_DIV - 1));

  always_comb begin
    gnt = '0;
`ifdef NOTE_LINK_DIAG_PRIORITY_EN
    if (src_vld[1])                  gnt = 2'b10;
    else if (src_vld[0] && !link.hold) gnt = 2'b01;
`else
    if (!link.hold) begin
      case (src_vld)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_grant_q ? 2'b01 : 2'b10;
        default: gnt = '0;
      endcase
    end
`endif
  end

  // Slot phase sequencing; PH_IDLE is the pre-first-frame state after reset.
  always_comb begin
    ph_d     = ph_q;
    slot_d   = slot_q;
    boundary = 1'b0;
    if (tick) begin
      case (ph_q)
        PH_DATA: begin
          slot_d = slot_q + SW'(1);
          if (slot_q == SW'(NOTES - 1))
            ph_d = (NOTES == FRAME_LEN - 1) ? PH_SYNC : PH_PAD;
        end
        PH_PAD: begin
          slot_d = slot_q + SW'(1);
          if (slot_q == SW'(FRAME_LEN - 2)) ph_d = PH_SYNC;
        end
        default: begin
          boundary = 1'b1;
          slot_d   = '0;
          ph_d     = PH_DATA;
        end
      endcase
    end
  end

  always_comb begin
    bit_sel = 1'b0;
    for (int i = 0; i < NOTES; i++)
      if (slot_d == SW'(i)) bit_sel = shadow_q[i];
  end

  // Slot 0 carries bit 0 of the vector selected on this same edge.
  always_comb begin
    shadow_d = (|gnt) ? src_notes[gnt[1]] : shadow_q;
    data_d   = 1'b0;
    if (ph_d == PH_DATA) data_d = boundary ? shadow_d[0] : bit_sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q     <= '0;
      ph_q          <= PH_IDLE;
      slot_q        <= '0;
      shadow_q      <= '0;
      last_grant_q  <= 1'b1;
      owner_q       <= 1'b0;
      refresh_q     <= 1'b0;
      data_q        <= 1'b0;
      sync_q        <= 1'b0;
      frame_start_q <= 1'b0;
      game_ready_q  <= 1'b0;
      diag_ready_q  <= 1'b0;
    end else begin
      div_cnt_q     <= tick ? '0 : div_cnt_q + DW'(1);
      frame_start_q <= boundary;
      game_ready_q  <= boundary & gnt[0];
      diag_ready_q  <= boundary & gnt[1];
      if (tick) begin
        ph_q   <= ph_d;
        slot_q <= slot_d;
        data_q <= data_d;
        sync_q <= (ph_d == PH_SYNC);
      end
      if (boundary) begin
        if (|gnt) begin
          shadow_q     <= shadow_d;
          owner_q      <= gnt[1];
          last_grant_q <= gnt[1];
          refresh_q    <= 1'b0;
        end else begin
          refresh_q    <= 1'b1;
        end
      end
    end
  end

  assign link.note_serial_data = data_q;
  assign link.note_serial_sync = sync_q;
  assign link.frame_start      = frame_start_q;
  assign link.owner            = owner_q;
  assign link.refresh          = refresh_q;
  assign link.game_ready       = game_ready_q;
  assign link.diag_ready       = diag_ready_q;
endmodule
